// File: rtl/wta_disparity_if.sv
// Cost-bus / result interface for wta_disparity.
//
// Signals:
//   i_data  - flattened cost bus, slice [k*NOBIT +: NOBIT] is the cost for disparity k
//   i_dval  - beat qualifier, the selector pipeline advances only when high
//   o_dval  - one-cycle strobe marking a new result
//   o_disp  - winning disparity index
//   o_cost  - winning cost
//   o_inval - result rejected by the optional threshold check
//
// Modports: master drives the cost bus and observes results, slave is the selector.
interface wta_disparity_if #(
    parameter int unsigned D     = 64,
    parameter int unsigned NOBIT = 12,
    parameter int unsigned NDBIT = 6
);
    logic [D*NOBIT-1:0] i_data;
    logic               i_dval;
    logic               o_dval;
    logic [NDBIT-1:0]   o_disp;
    logic [NOBIT-1:0]   o_cost;
    logic               o_inval;

    modport master (
        output i_data,
        output i_dval,
        input  o_dval,
        input  o_disp,
        input  o_cost,
        input  o_inval
    );

    modport slave (
        input  i_data,
        input  i_dval,
        output o_dval,
        output o_disp,
        output o_cost,
        output o_inval
    );
endinterface

// File: rtl/wta_disparity.sv
// Winner-take-all disparity selector.
//
// Takes D windowed cost values per pixel beat and reduces them through a registered binary
// minimum tree (2^L leaves, L = clog2(D)). Disparities reaching past the left image border of
// the current column are forced to the all-ones cost. Pad leaves (index >= D) also carry the
// all-ones cost. On equal costs the lower index wins, so masked or pad leaves never beat a
// real leaf of the same cost and an all-equal input yields disparity 0.
//
// Ports:
//   i_clk   - clock
//   i_rstn  - asynchronous active-low reset
//   bus     - wta_disparity_if.slave: i_data/i_dval in, o_dval/o_disp/o_cost/o_inval out
//
// Optional feature macro: WTA_THRESH_EN
//   defined   - o_inval = (o_cost > THRESH); o_disp reads 0 while o_inval is high
//   undefined - o_inval tied to 0, no comparator built, THRESH unused
//
// Latency is L+1 beats including the leaf sample; gaps in i_dval stall the whole pipeline.
module wta_disparity #(
    parameter int unsigned WC     = 7,
    parameter int unsigned WH     = 13,
    parameter int unsigned M      = 650,
    parameter int unsigned D      = 64,
    parameter int unsigned THRESH = 2000
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    wta_disparity_if.slave bus
);
    localparam int unsigned NOBIT = $clog2(((WC ** 2) / 2) * (WH ** 2));
    localparam int unsigned L     = $clog2(D);
    localparam int unsigned NDBIT = (L > 0) ? L : 1;
    localparam int unsigned NLeaf = 2 ** L;
    // Heap layout: node 0 is the root, children of j are 2j+1 / 2j+2, leaves start at Leaf0.
    localparam int unsigned NNode = 2 * NLeaf - 1;
    localparam int unsigned Leaf0 = NLeaf - 1;
    localparam int unsigned ColW  = (M > 1) ? $clog2(M) : 1;

    logic [NOBIT-1:0] cost_q [NNode];
    logic [NOBIT-1:0] cost_d [NNode];
    logic [NDBIT-1:0] idx_q  [NNode];
    logic [NDBIT-1:0] idx_d  [NNode];

    logic [ColW-1:0]  col_q, col_d;
    logic [L-1:0]     vld_q, vld_d;
    logic             dval_q, dval_d;

    // ------------------------------------------------------------------
    // Leaf stage: sample costs, apply left-border mask, pad to 2^L leaves
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NLeaf; k++) begin : g_leaf
        localparam int unsigned K = k;
        if (K < D) begin : g_real
            logic masked;
            // col_q indexes the beat being sampled; disparity k needs k pixels to its left.
            assign masked           = (32'(col_q) < K);
            assign cost_d[Leaf0+K]  = masked ? '1 : bus.i_data[K*NOBIT +: NOBIT];
            assign idx_d[Leaf0+K]   = NDBIT'(K);
        end else begin : g_pad
            assign cost_d[Leaf0+K]  = '1;
            assign idx_d[Leaf0+K]   = NDBIT'(K);
        end
    end

    // ------------------------------------------------------------------
    // Internal nodes: each registers the lesser of its two children
    // ------------------------------------------------------------------
    for (genvar j = 0; j < Leaf0; j++) begin : g_node
        localparam int unsigned J = j;
        logic take_right;
        // Left subtree always holds the lower indices, so strict < gives lower-index-wins.
        assign take_right = (cost_q[2*J+2] < cost_q[2*J+1]);
        assign cost_d[J]  = take_right ? cost_q[2*J+2] : cost_q[2*J+1];
        assign idx_d[J]   = take_right ? idx_q[2*J+2]  : idx_q[2*J+1];
    end

    // ------------------------------------------------------------------
    // Column counter and valid tracking
    // ------------------------------------------------------------------
    always_comb begin
        col_d  = col_q;
        vld_d  = vld_q;
        dval_d = 1'b0;
        if (bus.i_dval) begin
            col_d  = (col_q == ColW'(M - 1)) ? '0 : col_q + 1'b1;
            vld_d  = L'({vld_q, 1'b1});
            dval_d = vld_q[L-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cost_q <= '{default: '0};
            idx_q  <= '{default: '0};
            col_q  <= '0;
            vld_q  <= '0;
            dval_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            vld_q  <= vld_d;
            dval_q <= dval_d;
            if (bus.i_dval) begin
                cost_q <= cost_d;
                idx_q  <= idx_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, driven from the root register
    // ------------------------------------------------------------------
    assign bus.o_dval = dval_q;
    assign bus.o_cost = cost_q[0];

`ifdef WTA_THRESH_EN
    logic inval;
    assign inval       = (64'(cost_q[0]) > 64'(THRESH));
    assign bus.o_inval = inval;
    assign bus.o_disp  = inval ? '0 : idx_q[0];
`else
    assign bus.o_inval = 1'b0;
    assign bus.o_disp  = idx_q[0];
`endif

endmodule

// File: tb/tb_wta_disparity.sv
// Bench for wta_disparity: a D=8 and a D=5 instance share one cost stream (D=5 sees the low
// five slices). Expected results are queued per beat and checked when o_dval is due.
module tb_wta_disparity;
    localparam int unsigned D      = 8;
    localparam int unsigned D5     = 5;
    localparam int unsigned M      = 16;
    localparam int unsigned NOBIT  = 12;
    localparam int unsigned L      = 3;
    localparam int unsigned THRESH = 200;
`ifdef WTA_THRESH_EN
    localparam bit ThrEn = 1'b1;
`else
    localparam bit ThrEn = 1'b0;
`endif

    typedef logic [NOBIT-1:0] cost_arr_t [D];
    typedef struct {
        cost_arr_t        c;
        logic [2:0]       disp;
        logic [NOBIT-1:0] cost;
    } vec_t;
    typedef struct {
        logic [2:0]       disp;
        logic [NOBIT-1:0] cost;
        int               issue;
    } sb_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wta_disparity_if #(.D(D),  .NOBIT(NOBIT), .NDBIT(3)) bus8 ();
    wta_disparity_if #(.D(D5), .NOBIT(NOBIT), .NDBIT(3)) bus5 ();

    assign bus5.i_data = bus8.i_data[D5*NOBIT-1:0];
    assign bus5.i_dval = bus8.i_dval;

    wta_disparity #(.WC(7), .WH(13), .M(M), .D(D), .THRESH(THRESH)) dut8 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus8)
    );

    wta_disparity #(.WC(7), .WH(13), .M(M), .D(D5), .THRESH(THRESH)) dut5 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus5)
    );

    logic             od    [2];
    logic [2:0]       odisp [2];
    logic [NOBIT-1:0] ocost [2];
    logic             oinv  [2];
    assign od[0]    = bus8.o_dval;
    assign odisp[0] = bus8.o_disp;
    assign ocost[0] = bus8.o_cost;
    assign oinv[0]  = bus8.o_inval;
    assign od[1]    = bus5.o_dval;
    assign odisp[1] = bus5.o_disp;
    assign ocost[1] = bus5.o_cost;
    assign oinv[1]  = bus5.o_inval;

    sb_t sb [2][$];
    int  beat_cnt  = 0;
    int  col_m     = 0;
    int  n_vec     = 0;
    int  n_err     = 0;
    bit  last_beat = 1'b0;
    vec_t tab [8];

    task automatic chk(input string name, input int u, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (D=%0d) t=%0t: got %0d, expected %0d", name,
                     (u == 0) ? D : D5, $time, got, exp);
        end
    endtask

    // Reference: linear scan over eligible disparities, first strict minimum wins.
    function automatic void model(input cost_arr_t c, input int col, input int nd,
                                  output logic [2:0] disp, output logic [NOBIT-1:0] cost);
        disp = 3'd0;
        cost = c[0];
        for (int k = 1; k < nd; k++) begin
            if (k <= col && c[k] < cost) begin
                cost = c[k];
                disp = 3'(k);
            end
        end
    endfunction

    function automatic logic exp_inval(input logic [NOBIT-1:0] cost);
        return ThrEn && (int'(cost) > int'(THRESH));
    endfunction

    // Monitor: every cycle out of reset, o_dval must match the queue's due entry.
    always @(negedge clk) begin : monitor
        bit  exp_dv;
        sb_t e;
        if (rstn) begin
            for (int u = 0; u < 2; u++) begin
                exp_dv = last_beat && (sb[u].size() > 0) &&
                         (sb[u][0].issue + int'(L) + 1 == beat_cnt);
                chk("o_dval", u, 32'(od[u]), 32'(exp_dv));
                if (exp_dv) begin
                    e = sb[u].pop_front();
                    if (od[u]) begin
                        chk("o_cost",  u, 32'(ocost[u]), 32'(e.cost));
                        chk("o_inval", u, 32'(oinv[u]),  32'(exp_inval(e.cost)));
                        chk("o_disp",  u, 32'(odisp[u]),
                            exp_inval(e.cost) ? 32'd0 : 32'(e.disp));
                    end
                end
            end
        end
    end

    // One beat; tab_en selects hand-derived D=8 expectations instead of the model.
    task automatic beat(input cost_arr_t c, input bit tab_en, input logic [2:0] tdisp,
                        input logic [NOBIT-1:0] tcost);
        sb_t e8, e5;
        model(c, col_m, D, e8.disp, e8.cost);
        if (tab_en) begin
            e8.disp = tdisp;
            e8.cost = tcost;
        end
        model(c, col_m, D5, e5.disp, e5.cost);
        e8.issue = beat_cnt;
        e5.issue = beat_cnt;
        sb[0].push_back(e8);
        sb[1].push_back(e5);
        for (int k = 0; k < D; k++) bus8.i_data[k*NOBIT +: NOBIT] = c[k];
        bus8.i_dval = 1'b1;
        @(posedge clk);
        beat_cnt++;
        last_beat = 1'b1;
        col_m = (col_m == M - 1) ? 0 : col_m + 1;
        #1;
    endtask

    task automatic idle(input int n);
        bus8.i_dval = 1'b0;
        repeat (n) begin
            @(posedge clk);
            last_beat = 1'b0;
            #1;
        end
    endtask

    task automatic do_reset();
        bus8.i_dval = 1'b0;
        rstn = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst o_dval",  u, 32'(od[u]),    32'd0);
            chk("rst o_disp",  u, 32'(odisp[u]), 32'd0);
            chk("rst o_cost",  u, 32'(ocost[u]), 32'd0);
            chk("rst o_inval", u, 32'(oinv[u]),  32'd0);
        end
        repeat (2) @(posedge clk);
        sb[0].delete();
        sb[1].delete();
        beat_cnt  = 0;
        col_m     = 0;
        last_beat = 1'b0;
        #1;
        rstn = 1'b1;
    endtask

    task automatic rand_beats(input int n, input int maxc);
        cost_arr_t c;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < D; k++) c[k] = NOBIT'($urandom_range(0, maxc));
            beat(c, 1'b0, 3'd0, '0);
        end
    endtask

    initial begin
        cost_arr_t c;

        // Hand-derived vectors, applied at columns 8..15 where every disparity is eligible.
        for (int k = 0; k < D; k++) tab[0].c[k] = NOBIT'(50 + 10 * ((k > 5) ? k - 5 : 5 - k));
        tab[0].disp = 3'd5; tab[0].cost = 12'd50;
        for (int k = 0; k < D; k++) tab[1].c[k] = (k == 2 || k == 6) ? 12'd30 : 12'd90;
        tab[1].disp = 3'd2; tab[1].cost = 12'd30;
        for (int k = 0; k < D; k++) tab[2].c[k] = 12'hfff;
        tab[2].disp = 3'd0; tab[2].cost = 12'hfff;
        for (int k = 0; k < D; k++) tab[3].c[k] = (k == 7) ? 12'd200 : 12'd300;
        tab[3].disp = 3'd7; tab[3].cost = 12'd200;
        for (int k = 0; k < D; k++) tab[4].c[k] = (k == 0) ? 12'd0 : 12'd1;
        tab[4].disp = 3'd0; tab[4].cost = 12'd0;
        for (int k = 0; k < D; k++) tab[5].c[k] = NOBIT'(800 - 100 * k);
        tab[5].disp = 3'd7; tab[5].cost = 12'd100;
        for (int k = 0; k < D; k++) tab[6].c[k] = (k == 4) ? 12'd0 : 12'd100;
        tab[6].disp = 3'd4; tab[6].cost = 12'd0;
        for (int k = 0; k < D; k++) tab[7].c[k] = (k == 1 || k == 4) ? 12'd201 : 12'd300;
        tab[7].disp = 3'd1; tab[7].cost = 12'd201;

        rstn        = 1'b1;
        bus8.i_dval = 1'b0;
        bus8.i_data = '0;
        #2;
        do_reset();

        // All-equal costs: first result lands on the fourth beat, disparity 0.
        for (int k = 0; k < D; k++) c[k] = 12'd100;
        for (int i = 0; i < 4; i++) beat(c, 1'b1, 3'd0, 12'd100);

        // Descending costs at columns 4..7: the mask decides the winner.
        for (int k = 0; k < D; k++) c[k] = NOBIT'(300 - 20 * k);
        for (int i = 0; i < 4; i++) beat(c, 1'b0, 3'd0, '0);

        for (int i = 0; i < 8; i++) beat(tab[i].c, 1'b1, tab[i].disp, tab[i].cost);

        // Row start: k=3 only eligible from column 3; column 0 recurs after the wrap.
        for (int k = 0; k < D; k++) c[k] = (k == 3) ? 12'd10 : 12'd500;
        for (int i = 0; i < 17; i++) begin
            if (i == 0 || i == 16) beat(c, 1'b1, 3'd0, 12'd500);
            else if (i == 3)       beat(c, 1'b1, 3'd3, 12'd10);
            else                   beat(c, 1'b0, 3'd0, '0);
        end

        // Five-cycle gap in the middle of a stream, small costs to provoke ties.
        rand_beats(6, 31);
        idle(5);
        rand_beats(6, 31);
        idle(2);

        // Reset with tokens in flight, then a fresh stream.
        rand_beats(3, 4095);
        do_reset();
        rand_beats(8, 4095);
        rand_beats(4, 4095);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wta_disparity.md
# wta_disparity

Winner-take-all disparity selector placed directly downstream of the bank of D `window_SHD` instances, one instance per candidate disparity. Each pixel beat it takes the D windowed sum-of-Hamming-distance costs and runs them through a registered binary minimum tree. It emits the winning disparity index and its cost. Disparities that reach past the left image border of the current column are masked out.

## Interface
Parameters:
- `WC`, 7: census window side; used only for width derivation.
- `WH`, 13: aggregation window side; used only for width derivation.
- `M`, 650: pixels per image row; the column counter wraps at this value.
- `D`, 64: number of candidate disparities, D ≥ 2. Need not be a power of two.
- `THRESH`, 2000: maximum accepted cost. Used only with `WTA_THRESH_EN`.
- Derived widths:
  - `NOBIT = $clog2(((WC**2)/2)*(WH**2))`, which is 12 at defaults.
  - `NDBIT = $clog2(D)`, with a minimum of 1.
  - `L = $clog2(D)`, the number of tree levels.

Ports:
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `i_data`, in, D*NOBIT: flattened cost bus. Slice `[k*NOBIT +: NOBIT]` is the cost for disparity k.
- `i_dval`, in, 1: beat qualifier. The whole pipeline advances only on cycles where `i_dval` is 1.
- `o_dval`, out, 1: one-cycle strobe marking a new result.
- `o_disp`, out, NDBIT: winning disparity.
- `o_cost`, out, NOBIT: winning cost.
- `o_inval`, out, 1: result rejected by the threshold check. Constant 0 without `WTA_THRESH_EN`.

## Operation
- All costs compare as unsigned NOBIT values.
- Column counter `col`:
  - Reset value 0.
  - Increments on each `i_dval` beat.
  - Wraps from M-1 to 0.
  - It indexes the beat currently being sampled.
- Stage 0, sampled on a beat:
  - Slice k is registered together with its index k.
  - Any slice with k > `col` is replaced by the all-ones cost. This is the left-border mask; k=0 is never masked.
  - The tree is padded up to 2^L leaves. Pad leaves carry the all-ones cost and an index ≥ D.
- Levels 1..L: each node registers the lesser of its two children, as a (cost, index) pair.
- Tie-break: on equal costs the lower index wins. This guarantees:
  - a pad leaf or masked leaf never beats a real leaf of equal cost;
  - an all-equal input yields disparity 0.
- `o_disp` and `o_cost` are driven from the level-L register. They hold their value between beats.
- Valid tracking:
  - A shift register `vld[0..L]` advances on beats, with 1 entering `vld[0]`.
  - `o_dval` is registered: it takes the value of `vld[L-1]` on a beat and 0 on any non-beat cycle.
  - The first L beats after reset therefore produce no `o_dval`.
- Reset values: all pipeline registers 0, `vld` all 0, `col` 0, `o_dval` 0, `o_disp` 0, `o_cost` 0, `o_inval` 0.
- Reset asserted mid-stream discards every in-flight token and restarts `col` at 0.

## Timing
- Latency is L+1 beats, counting the stage-0 sample: the result for the beat sampled at edge n is presented after the beat edge L beats later.
  - Continuous `i_dval`: result valid L+1 cycles after input. At D=64 this is 7 cycles.
  - Gaps in `i_dval` stretch latency by exactly the gap length. No data is lost or duplicated.
- Throughput is one result per beat.
- `o_dval` never stays high across a non-beat cycle.
- `col` wraparound applies to the beat at column 0 of the next row: only disparity 0 is eligible for that pixel.

## Configuration
- `WTA_THRESH_EN` defined:
  - `o_inval = (o_cost > THRESH)`, combinational from the level-L register.
  - When `o_inval` is 1, `o_disp` reads 0. `o_cost` is unchanged.
- `WTA_THRESH_EN` undefined:
  - `o_inval` is tied to 0.
  - `THRESH` is unused.
  - No comparator is built.

## Test plan
All scenarios use D=8 (L=3), M=16, NOBIT=12 unless stated.
- Reset, then 4 continuous beats with all costs 100 → `o_dval` first high 4 cycles after the first beat; `o_disp`=0, `o_cost`=100.
- At `col`≥7, costs k → 50+10·|k−5| → `o_disp`=5, `o_cost`=50. Costs 30 at both k=2 and k=6, all others 90 → `o_disp`=2.
- Row start, every cost 500 except k=3 at 10:
  - `col`=0 → `o_disp`=0, `o_cost`=500.
  - `col`=3 → `o_disp`=3, `o_cost`=10.
  - After 16 beats `col` wraps and the masking repeats.
- Continuous stream with `i_dval` dropped for 5 cycles mid-stream → output sequence identical to the gap-free run; `o_dval` low throughout the gap.
- D=5 (padded to 8), minimum at k=4 with cost 0 → `o_disp`=4; no pad index ever appears on `o_disp`.
- With `WTA_THRESH_EN` defined and THRESH=200, minimum cost 201 → `o_inval`=1, `o_disp`=0, `o_cost`=201. Minimum cost 200 → `o_inval`=0.
